// File: rtl/mc_pkg.sv
// Purpose: shared types and encodings for the multicycle controller.
//   state_t      : FSM state register type plus its state constants
//   OP_*         : instr[27:26] instruction class encodings
//   SRCA_/SRCB_/RES_/IMM_* : datapath select encodings
//   ctrl_t       : packed bundle of every control strobe the FSM drives
package mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH  = 4'd0;
    localparam state_t S_FWAIT  = 4'd1;
    localparam state_t S_DECODE = 4'd2;
    localparam state_t S_MEMADR = 4'd3;
    localparam state_t S_MEMRD  = 4'd4;
    localparam state_t S_MEMWR  = 4'd5;
    localparam state_t S_MEMWB  = 4'd6;
    localparam state_t S_EXECR  = 4'd7;
    localparam state_t S_EXECI  = 4'd8;
    localparam state_t S_ALUWB  = 4'd9;
    localparam state_t S_BRANCH = 4'd10;
    localparam state_t S_FAULT  = 4'd11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [1:0] SRCA_RN     = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    typedef struct packed {
        logic       mem_req;
        logic       adrSrc;
        logic       irWrite;
        logic       pcWrite;
        logic       regW;
        logic       memW;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] resultSrc;
        logic       aluOp;
        logic [1:0] immSrc;
        logic [1:0] regSrc;
        logic       fault;
    } ctrl_t;

    // Compare-style commands only set flags; they never write a register.
    function automatic logic writes_rf(input logic [3:0] cmd);
        return !((cmd == CMD_TST) || (cmd == CMD_CMP));
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Purpose: controller <-> datapath/memory bundle.
//   instruction fields op/funct/rd, condEx and mem_ready flow into the controller;
//   mem_req/memW and the datapath selects/enables flow out of it, plus fault.
//   master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       condEx;
    logic       mem_ready;

    logic       mem_req;
    logic       adrSrc;
    logic       irWrite;
    logic       pcWrite;
    logic       regW;
    logic       memW;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic       aluOp;
    logic [1:0] immSrc;
    logic [1:0] regSrc;
    logic       fault;

    modport master (
        input  op, funct, rd, condEx, mem_ready,
        output mem_req, adrSrc, irWrite, pcWrite, regW, memW,
               aluSrcA, aluSrcB, resultSrc, aluOp, immSrc, regSrc, fault
    );

    modport slave (
        output op, funct, rd, condEx, mem_ready,
        input  mem_req, adrSrc, irWrite, pcWrite, regW, memW,
               aluSrcA, aluSrcB, resultSrc, aluOp, immSrc, regSrc, fault
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Purpose: saturating wait counter shared by every memory wait state.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : zero the count (state entry)
//   en_i       : a wait cycle is in progress (request pending, no ready)
//   timeout_o  : this wait cycle is the last one allowed
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TW          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam int unsigned LIMIT = MEM_TIMEOUT - 1;

    logic [TW-1:0] cnt_q, cnt_d;
    logic          at_limit_c;

    assign at_limit_c = (cnt_q == TW'(LIMIT));
    assign timeout_o  = en_i & at_limit_c;

    // Count up while waiting; hold at the limit rather than wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !at_limit_c) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: multicycle control FSM for the shared ARM-subset datapath.
//   clk, rst_n : clock, async active-low reset
//   bus        : multicycle_ctrl_if.master (instruction fields, condEx,
//                mem_ready in; memory request and datapath strobes out)
// Outputs are a decode of the current state; FETCH/FWAIT also look at
// mem_ready, and architectural writes are qualified by condEx.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TW          = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_c, out_c;
    logic       wait_en_c, timeout_c, tmr_clr_c;
    logic [3:0] cmd_c;
    logic       rd_is_pc_c;

    assign cmd_c      = bus.funct[4:1];
    assign rd_is_pc_c = (bus.rd == 4'd15);

    // Only cycles that are actually stalled on memory count toward timeout.
    assign wait_en_c = ((state_q == S_FWAIT) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                       && !bus.mem_ready;
    // Any state change restarts the wait budget.
    assign tmr_clr_c = (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TW          (TW)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmr_clr_c),
        .en_i      (wait_en_c),
        .timeout_o (timeout_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control decode.
    always_comb begin
        state_d = state_q;
        ctrl_c  = '0;
        case (state_q)
            S_FETCH, S_FWAIT: begin
                ctrl_c.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ctrl_c.irWrite   = 1'b1;
                    ctrl_c.pcWrite   = 1'b1;
                    ctrl_c.aluSrcA   = SRCA_PC;
                    ctrl_c.aluSrcB   = SRCB_FOUR;
                    ctrl_c.resultSrc = RES_ALU;
                    state_d          = S_DECODE;
                end else if (state_q == S_FETCH) begin
                    state_d = S_FWAIT;
                end else if (timeout_c) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                ctrl_c.aluSrcA = SRCA_PC;
                ctrl_c.aluSrcB = SRCB_FOUR;
                case (bus.op)
                    OP_MEM: begin
                        ctrl_c.immSrc = IMM_12;
                        ctrl_c.regSrc = 2'b10;
                    end
                    OP_BR: begin
                        ctrl_c.immSrc = IMM_24;
                        ctrl_c.regSrc = 2'b01;
                    end
                    default: begin
                        ctrl_c.immSrc = IMM_8;
                        ctrl_c.regSrc = 2'b00;
                    end
                endcase
                if (!bus.condEx) begin
                    state_d = S_FETCH;
                end else begin
                    case (bus.op)
                        OP_DP:   state_d = bus.funct[5] ? S_EXECI : S_EXECR;
                        OP_MEM:  state_d = S_MEMADR;
                        OP_BR:   state_d = S_BRANCH;
                        OP_ILL:  state_d = S_FAULT;
                        default: state_d = S_FAULT;
                    endcase
                end
            end
            S_EXECR, S_EXECI: begin
                ctrl_c.aluSrcA = SRCA_RN;
                ctrl_c.aluSrcB = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RM;
                ctrl_c.aluOp   = 1'b1;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_c.resultSrc = RES_ALUOUT;
                if (writes_rf(cmd_c)) begin
                    ctrl_c.pcWrite = rd_is_pc_c & bus.condEx;
                    ctrl_c.regW    = !rd_is_pc_c & bus.condEx;
                end
                state_d = S_FETCH;
            end
            S_MEMADR: begin
                ctrl_c.aluSrcA = SRCA_RN;
                ctrl_c.aluSrcB = SRCB_IMM;
                state_d        = bus.funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD, S_MEMWR: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.adrSrc  = 1'b1;
                ctrl_c.memW    = (state_q == S_MEMWR) & bus.condEx;
                if (bus.mem_ready) begin
                    state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (timeout_c) begin
                    state_d = S_FAULT;
                end
            end
            S_MEMWB: begin
                ctrl_c.resultSrc = RES_DATA;
                ctrl_c.pcWrite   = rd_is_pc_c & bus.condEx;
                ctrl_c.regW      = !rd_is_pc_c & bus.condEx;
                state_d          = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_c.aluSrcA   = SRCA_ALUOUT;
                ctrl_c.aluSrcB   = SRCB_IMM;
                ctrl_c.immSrc    = IMM_24;
                ctrl_c.resultSrc = RES_ALU;
                ctrl_c.pcWrite   = bus.condEx;
                state_d          = S_FETCH;
            end
            S_FAULT: begin
                ctrl_c.fault = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // While reset is held every strobe is forced low, so an in-flight
    // request drops together with the asynchronous state reset.
    assign out_c = rst_n ? ctrl_c : '0;

    assign bus.mem_req   = out_c.mem_req;
    assign bus.adrSrc    = out_c.adrSrc;
    assign bus.irWrite   = out_c.irWrite;
    assign bus.pcWrite   = out_c.pcWrite;
    assign bus.regW      = out_c.regW;
    assign bus.memW      = out_c.memW;
    assign bus.aluSrcA   = out_c.aluSrcA;
    assign bus.aluSrcB   = out_c.aluSrcB;
    assign bus.resultSrc = out_c.resultSrc;
    assign bus.aluOp     = out_c.aluOp;
    assign bus.immSrc    = out_c.immSrc;
    assign bus.regSrc    = out_c.regSrc;
    assign bus.fault     = out_c.fault;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose: self-checking bench for multicycle_ctrl: directed vector table,
// hand-written timeout/fault/reset sequences, and random instruction
// streams checked against a per-instruction cycle-trace model.
module tb_multicycle_ctrl;

    localparam int unsigned MT = 16;

    typedef struct packed {
        logic       mem_req;
        logic       adrSrc;
        logic       irWrite;
        logic       pcWrite;
        logic       regW;
        logic       memW;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] resultSrc;
        logic       aluOp;
        logic [1:0] immSrc;
        logic [1:0] regSrc;
        logic       fault;
    } exp_t;

    typedef struct {
        logic       rdy;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic       cond;
        exp_t       exp;
    } cyc_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .MEM_TIMEOUT (MT),
        .TW          (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    cyc_t q[$];
    cyc_t cur;

    function automatic exp_t mk(input bit mreq, adr, ir, pcw, rw, mw,
                                input logic [1:0] a, b, res,
                                input bit aop,
                                input logic [1:0] imm, rs);
        exp_t e;
        e = '0;
        e.mem_req = mreq; e.adrSrc = adr; e.irWrite = ir; e.pcWrite = pcw;
        e.regW = rw; e.memW = mw; e.aluSrcA = a; e.aluSrcB = b;
        e.resultSrc = res; e.aluOp = aop; e.immSrc = imm; e.regSrc = rs;
        return e;
    endfunction

    function automatic cyc_t cy(input logic rdy, input logic [1:0] op,
                                input logic [5:0] funct, input logic [3:0] rd,
                                input logic cond, input exp_t e);
        cyc_t c;
        c.rdy = rdy; c.op = op; c.funct = funct; c.rd = rd; c.cond = cond; c.exp = e;
        return c;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.mem_req = bus.mem_req; a.adrSrc = bus.adrSrc; a.irWrite = bus.irWrite;
        a.pcWrite = bus.pcWrite; a.regW = bus.regW; a.memW = bus.memW;
        a.aluSrcA = bus.aluSrcA; a.aluSrcB = bus.aluSrcB; a.resultSrc = bus.resultSrc;
        a.aluOp = bus.aluOp; a.immSrc = bus.immSrc; a.regSrc = bus.regSrc;
        a.fault = bus.fault;
        return a;
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = sample();
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s check#%0d: got %05h want %05h", name, n_total, a, e);
    endtask

    // One clock cycle: drive inputs after the falling edge, sample before the rising edge.
    task automatic apply(input cyc_t c, input string name);
        @(negedge clk);
        bus.mem_ready = c.rdy; bus.op = c.op; bus.funct = c.funct;
        bus.rd = c.rd; bus.condEx = c.cond;
        #2;
        check(name, c.exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        #2;
        check("reset_outputs", '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- reference model: per-instruction cycle trace ----------------
    exp_t fe, fw, fv;

    task automatic push(input logic rdy, input exp_t e);
        cyc_t c;
        c = cur; c.rdy = rdy; c.exp = e;
        q.push_back(c);
    endtask

    task automatic push_fault();
        for (int i = 0; i < 3; i++) push(1'($urandom_range(0, 1)), fv);
    endtask

    // flat: not-ready cycles before fetch completes (fetch allows MT waits after its first cycle)
    // mlat: not-ready cycles before a data access completes (MT cycles allowed in total)
    task automatic model_instr(input logic [1:0] op, input logic [5:0] funct,
                               input logic [3:0] rd, input logic cond,
                               input int flat, input int mlat, output bit faulted);
        bit   done, wr;
        exp_t e;
        cur = cy(1'b0, op, funct, rd, cond, '0);
        faulted = 1'b0;
        done = 1'b0;
        for (int i = 0; i <= int'(MT); i++) begin
            if (i == flat) begin push(1'b1, fe); done = 1'b1; break; end
            push(1'b0, fw);
        end
        if (!done) begin push_fault(); faulted = 1'b1; return; end
        e = mk(0,0,0,0,0,0, 2'b01, 2'b10, 2'b00, 0,
               (op == 2'd1) ? 2'b01 : (op == 2'd2) ? 2'b10 : 2'b00,
               (op == 2'd1) ? 2'b10 : (op == 2'd2) ? 2'b01 : 2'b00);
        push(1'($urandom_range(0, 1)), e);
        if (!cond) return;
        case (op)
            2'd0: begin
                push(1'($urandom_range(0, 1)), mk(0,0,0,0,0,0, 2'b00, funct[5] ? 2'b01 : 2'b00, 2'b00, 1, 2'b00, 2'b00));
                wr = !(funct[4:1] inside {4'b1010, 4'b1000});
                push(1'($urandom_range(0, 1)), mk(0,0,0, wr && rd == 4'd15, wr && rd != 4'd15, 0, 0, 0, 0, 0, 0, 0));
            end
            2'd1: begin
                push(1'($urandom_range(0, 1)), mk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b00, 0, 2'b00, 2'b00));
                e = mk(1, 1, 0, 0, 0, !funct[0], 0, 0, 0, 0, 0, 0);
                done = 1'b0;
                for (int i = 0; i < int'(MT); i++) begin
                    if (i == mlat) begin push(1'b1, e); done = 1'b1; break; end
                    push(1'b0, e);
                end
                if (!done) begin push_fault(); faulted = 1'b1; return; end
                if (funct[0])
                    push(1'($urandom_range(0, 1)), mk(0,0,0, rd == 4'd15, rd != 4'd15, 0, 0, 0, 2'b01, 0, 0, 0));
            end
            2'd2: push(1'($urandom_range(0, 1)), mk(0,0,0,1,0,0, 2'b10, 2'b01, 2'b10, 0, 2'b10, 2'b00));
            default: begin push_fault(); faulted = 1'b1; end
        endcase
    endtask

    function automatic int pick_lat(input int max_ok);
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 3)  return max_ok + 1;
        if (r < 15) return int'($urandom_range(0, max_ok));
        return int'($urandom_range(0, 3));
    endfunction

    cyc_t tbl[$];

    initial begin
        exp_t dec0, dec1, dec2, memrd, memwr;
        bit   flt;

        fe = mk(1,0,1,1,0,0, 2'b01, 2'b10, 2'b10, 0, 2'b00, 2'b00);
        fw = mk(1,0,0,0,0,0, 0, 0, 0, 0, 0, 0);
        fv = '0; fv.fault = 1'b1;
        dec0  = mk(0,0,0,0,0,0, 2'b01, 2'b10, 2'b00, 0, 2'b00, 2'b00);
        dec1  = mk(0,0,0,0,0,0, 2'b01, 2'b10, 2'b00, 0, 2'b01, 2'b10);
        dec2  = mk(0,0,0,0,0,0, 2'b01, 2'b10, 2'b00, 0, 2'b10, 2'b01);
        memrd = mk(1,1,0,0,0,0, 0, 0, 0, 0, 0, 0);
        memwr = mk(1,1,0,0,0,1, 0, 0, 0, 0, 0, 0);

        // ADD R1,R2,#5
        tbl.push_back(cy(1, 2'd0, 6'b101000, 4'd1, 1, fe));
        tbl.push_back(cy(1, 2'd0, 6'b101000, 4'd1, 1, dec0));
        tbl.push_back(cy(1, 2'd0, 6'b101000, 4'd1, 1, mk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b00, 1, 0, 0)));
        tbl.push_back(cy(1, 2'd0, 6'b101000, 4'd1, 1, mk(0,0,0,0,1,0, 0, 0, 0, 0, 0, 0)));
        // LDR R3 with ready delayed 3 cycles
        tbl.push_back(cy(1, 2'd1, 6'b011001, 4'd3, 1, fe));
        tbl.push_back(cy(1, 2'd1, 6'b011001, 4'd3, 1, dec1));
        tbl.push_back(cy(1, 2'd1, 6'b011001, 4'd3, 1, mk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b00, 0, 0, 0)));
        tbl.push_back(cy(0, 2'd1, 6'b011001, 4'd3, 1, memrd));
        tbl.push_back(cy(0, 2'd1, 6'b011001, 4'd3, 1, memrd));
        tbl.push_back(cy(0, 2'd1, 6'b011001, 4'd3, 1, memrd));
        tbl.push_back(cy(1, 2'd1, 6'b011001, 4'd3, 1, memrd));
        tbl.push_back(cy(0, 2'd1, 6'b011001, 4'd3, 1, mk(0,0,0,0,1,0, 0, 0, 2'b01, 0, 0, 0)));
        // STR with one wait cycle
        tbl.push_back(cy(1, 2'd1, 6'b011000, 4'd4, 1, fe));
        tbl.push_back(cy(1, 2'd1, 6'b011000, 4'd4, 1, dec1));
        tbl.push_back(cy(1, 2'd1, 6'b011000, 4'd4, 1, mk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b00, 0, 0, 0)));
        tbl.push_back(cy(0, 2'd1, 6'b011000, 4'd4, 1, memwr));
        tbl.push_back(cy(1, 2'd1, 6'b011000, 4'd4, 1, memwr));
        // B taken
        tbl.push_back(cy(1, 2'd2, 6'b100000, 4'd0, 1, fe));
        tbl.push_back(cy(1, 2'd2, 6'b100000, 4'd0, 1, dec2));
        tbl.push_back(cy(1, 2'd2, 6'b100000, 4'd0, 1, mk(0,0,0,1,0,0, 2'b10, 2'b01, 2'b10, 0, 2'b10, 0)));
        // B not taken: DECODE falls straight back to FETCH
        tbl.push_back(cy(1, 2'd2, 6'b100000, 4'd0, 0, fe));
        tbl.push_back(cy(1, 2'd2, 6'b100000, 4'd0, 0, dec2));
        tbl.push_back(cy(0, 2'd2, 6'b100000, 4'd0, 0, fw));
        // CMP: fetch completes from the wait state, no register write
        tbl.push_back(cy(1, 2'd0, 6'b010101, 4'd2, 1, fe));
        tbl.push_back(cy(1, 2'd0, 6'b010101, 4'd2, 1, dec0));
        tbl.push_back(cy(1, 2'd0, 6'b010101, 4'd2, 1, mk(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1, 0, 0)));
        tbl.push_back(cy(1, 2'd0, 6'b010101, 4'd2, 1, '0));
        // ADD PC,... (rd=15): pcWrite instead of regW
        tbl.push_back(cy(1, 2'd0, 6'b001000, 4'd15, 1, fe));
        tbl.push_back(cy(1, 2'd0, 6'b001000, 4'd15, 1, dec0));
        tbl.push_back(cy(1, 2'd0, 6'b001000, 4'd15, 1, mk(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1, 0, 0)));
        tbl.push_back(cy(1, 2'd0, 6'b001000, 4'd15, 1, mk(0,0,0,1,0,0, 0, 0, 0, 0, 0, 0)));

        bus.mem_ready = 1'b0; bus.op = '0; bus.funct = '0; bus.rd = '0; bus.condEx = 1'b0;
        #2;
        check("reset_initial", '0);
        do_reset();

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], "table");

        // Fetch timeout: FETCH plus MT stalled wait cycles, then sticky FAULT.
        for (int i = 0; i <= int'(MT); i++) apply(cy(0, 2'd0, 6'd0, 4'd0, 1, fw), "fetch_wait");
        for (int i = 0; i < 3; i++) apply(cy(1, 2'd0, 6'd0, 4'd0, 1, fv), "fault_sticky");
        do_reset();
        apply(cy(1, 2'd3, 6'd0, 4'd0, 1, fe), "fetch_after_reset");
        // Illegal op traps from DECODE.
        apply(cy(1, 2'd3, 6'd0, 4'd0, 1, dec0), "illegal_decode");
        apply(cy(1, 2'd3, 6'd0, 4'd0, 1, fv), "illegal_fault");
        do_reset();
        // Reset in the middle of a pending fetch drops mem_req.
        apply(cy(0, 2'd0, 6'd0, 4'd0, 1, fw), "fetch_pending");
        do_reset();

        // Random instruction stream against the trace model.
        for (int n = 0; n < 250; n++) begin
            logic [1:0] op;
            op = ($urandom_range(0, 99) < 4) ? 2'd3 : 2'($urandom_range(0, 2));
            model_instr(op, 6'($urandom), 4'($urandom), ($urandom_range(0, 9) < 8),
                        pick_lat(int'(MT)), pick_lat(int'(MT) - 1), flt);
            while (q.size() > 0) apply(q.pop_front(), "random");
            if (flt) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
